// File: rtl/chunks_core.sv
// SHA-256 compression engine: hashes 512-bit chunks on entry to HASH_STATE and chains H across chunks.
// Optional macro CHUNKS_UNROLL2_EN computes two rounds per cycle (32 round cycles instead of 64).
module chunks_core #(
  parameter logic [2:0] HASH_STATE = 3'h4,
  parameter logic [2:0] IDLE_STATE = 3'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [2:0]   state,
  input  logic [511:0] chunk,
  output logic [255:0] HASH
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Word i of the schedule window; word 0 is the W used by the current round.
  function automatic logic [31:0] word(input logic [511:0] v, input int i);
    return v[511 - 32*i -: 32];
  endfunction

  // One compression round; kw is K[t] + W[t] already summed.
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] kw);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + kw;
    t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [255:0] hash_q, hash_d;
  logic [255:0] h_q, h_d;
  logic [255:0] work_q, work_d;
  logic [511:0] w_q, w_d;
  logic [6:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic [2:0]   prev_state_q, prev_state_d;
  logic         start;
  logic [31:0]  w_new0;
`ifdef CHUNKS_UNROLL2_EN
  logic [31:0]  w_new1;
  logic [255:0] work_mid;
`endif

  assign start  = (state == HASH_STATE) && (prev_state_q != HASH_STATE) && !busy_q;
  assign w_new0 = small_s1(word(w_q, 14)) + word(w_q, 9) + small_s0(word(w_q, 1)) + word(w_q, 0);
`ifdef CHUNKS_UNROLL2_EN
  assign w_new1 = small_s1(word(w_q, 15)) + word(w_q, 10) + small_s0(word(w_q, 2)) + word(w_q, 1);
  assign work_mid = sha_round(work_q, K[round_q[5:0]] + word(w_q, 0));
`endif

  always_comb begin
    hash_d       = hash_q;
    h_d          = h_q;
    work_d       = work_q;
    w_d          = w_q;
    round_d      = round_q;
    busy_d       = busy_q;
    prev_state_d = state;
    // IDLE restarts the digest chain and drops any in-flight chunk, but keeps HASH visible.
    if (state == IDLE_STATE) begin
      h_d    = IV;
      busy_d = 1'b0;
    end else if (start) begin
      w_d     = chunk;
      work_d  = h_q;
      busy_d  = 1'b1;
      round_d = 7'd0;
    end else if (busy_q) begin
      if (round_q == 7'd64) begin
        for (int i = 0; i < 8; i++) begin
          h_d[255 - 32*i -: 32] = h_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
        end
        hash_d = h_d;
        busy_d = 1'b0;
      end else begin
`ifdef CHUNKS_UNROLL2_EN
        work_d  = sha_round(work_mid, K[round_q[5:0] | 6'd1] + word(w_q, 1));
        w_d     = {w_q[447:0], w_new0, w_new1};
        round_d = round_q + 7'd2;
`else
        work_d  = sha_round(work_q, K[round_q[5:0]] + word(w_q, 0));
        w_d     = {w_q[479:0], w_new0};
        round_d = round_q + 7'd1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hash_q       <= '0;
      h_q          <= IV;
      work_q       <= '0;
      w_q          <= '0;
      round_q      <= '0;
      busy_q       <= 1'b0;
      prev_state_q <= IDLE_STATE;
    end else begin
      hash_q       <= hash_d;
      h_q          <= h_d;
      work_q       <= work_d;
      w_q          <= w_d;
      round_q      <= round_d;
      busy_q       <= busy_d;
      prev_state_q <= prev_state_d;
    end
  end

  assign HASH = hash_q;

endmodule

// File: tb/tb_chunks_core.sv
// Directed bench for chunks_core: known SHA-256 digests, chaining, abort, reset and busy re-entry.
module tb_chunks_core;

`ifdef CHUNKS_UNROLL2_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 66;
`endif

  localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clock;
  logic         reset;
  logic [2:0]   state;
  logic [511:0] chunk;
  logic [255:0] HASH;
  int           errors;
  int           checks;

  chunks_core dut (
    .clock(clock),
    .reset(reset),
    .state(state),
    .chunk(chunk),
    .HASH (HASH)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled on falling edges, clear of the active edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] expected);
    checks++;
    assert (HASH === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, HASH, expected);
    end
  endtask

  task automatic checkDiffers(input string tag, input logic [255:0] forbidden);
    checks++;
    assert (HASH !== forbidden) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected_not=%h", tag, HASH, forbidden);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    state  = 3'h0;
    chunk  = '0;
    #3 reset = 1'b0;
    applyStimulus(2);
    checkOutput("reset_zero", 256'h0);
    reset = 1'b1;
    applyStimulus(2);
    checkOutput("reset_release_hold", 256'h0);

    // Single-block "abc": digest lands exactly LAT edges after state goes to HASH.
    chunk = ABC;
    state = 3'h4;
    applyStimulus(LAT - 1);
    checkOutput("abc_not_early", 256'h0);
    applyStimulus(1);
    checkOutput("abc_digest", D_ABC);
    state = 3'h0;
    applyStimulus(2);
    checkOutput("idle_keeps_hash", D_ABC);

    chunk = EMPTY;
    state = 3'h4;
    applyStimulus(LAT - 1);
    checkOutput("empty_holds_prev", D_ABC);
    applyStimulus(1);
    checkOutput("empty_digest", D_EMPTY);

    // Two-block message chained through a non-IDLE state.
    state = 3'h0;
    applyStimulus(1);
    chunk = BLK1;
    state = 3'h4;
    applyStimulus(LAT);
    state = 3'h3;
    applyStimulus(2);
    chunk = BLK2;
    state = 3'h4;
    applyStimulus(LAT);
    checkOutput("two_block_digest", D_TWO);

    // Same blocks with IDLE in between restart from the IV.
    state = 3'h0;
    applyStimulus(1);
    chunk = BLK1;
    state = 3'h4;
    applyStimulus(LAT);
    state = 3'h0;
    applyStimulus(1);
    chunk = BLK2;
    state = 3'h4;
    applyStimulus(LAT);
    checkDiffers("chain_reset_differs", D_TWO);

    // Re-entry while busy, plus chunk churn, must not disturb the in-flight "abc".
    state = 3'h0;
    applyStimulus(1);
    chunk = ABC;
    state = 3'h4;
    applyStimulus(5);
    state = 3'h3;
    applyStimulus(1);
    chunk = EMPTY;
    state = 3'h4;
    applyStimulus(1);
    chunk = BLK1;
    state = 3'h3;
    applyStimulus(LAT - 8);
    checkDiffers("busy_not_early", D_ABC);
    applyStimulus(1);
    checkOutput("busy_reentry_ignored", D_ABC);

    // IDLE mid-compression aborts; HASH keeps the old digest.
    state = 3'h0;
    applyStimulus(1);
    chunk = EMPTY;
    state = 3'h4;
    applyStimulus(10);
    state = 3'h0;
    applyStimulus(LAT);
    checkOutput("idle_abort", D_ABC);

    // Asynchronous reset around round 30 clears HASH without a clock edge.
    chunk = EMPTY;
    state = 3'h4;
    applyStimulus(LAT / 2 - 2);
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_async_mid", 256'h0);
    state = 3'h0;
    applyStimulus(2);
    reset = 1'b1;
    applyStimulus(1);
    chunk = ABC;
    state = 3'h4;
    applyStimulus(LAT);
    checkOutput("abc_after_reset", D_ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
